qram_cmd_sequencer: RTL and testbench

Command/timing sequencer directly upstream of the QRAM SDRAM core (QRAM_inSDRAM). It accepts single-beat read/write requests over a valid/ready handshake and runs the power-up init sequence. It issues ACT/RD/WR/PRE/REF commands with programmed timing gaps, inserts periodic refresh, and returns read data with fixed latency. Requests are closed-page: exactly one access per activate.

---
 rtl/qram_ddr_pkg.sv | 51 +++++
 rtl/qram_gap_timer.sv | 36 +++
 rtl/qram_cmd_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_qram_cmd_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/qram_ddr_pkg.sv
// Shared definitions for the QRAM command sequencer: command encodings,
// sequencer states and the width of the reusable gap timer.
package qram_ddr_pkg;

    localparam int TIMER_W = 8;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } cmd_e;

    typedef enum logic [3:0] {
        S_INIT_WAIT,
        S_INIT_PRE,
        S_INIT_RP,
        S_INIT_REF,
        S_INIT_RFC,
        S_IDLE,
        S_ACT,
        S_TRCD,
        S_ACCESS,
        S_TDATA,
        S_PRE,
        S_TRP,
        S_REF,
        S_TRFC
    } state_e;

    // The timer counts down to zero inclusive, so a wait state that must
    // last N cycles is entered with N-1 loaded.
    function automatic logic [TIMER_W-1:0] gapLoad(input int residence);
        return (residence > 1) ? TIMER_W'(residence - 1) : '0;
    endfunction

    function automatic cmd_e stateCmd(input state_e s, input logic isWrite);
        cmd_e c;
        case (s)
            S_INIT_PRE, S_PRE: c = CMD_PRE;
            S_INIT_REF, S_REF: c = CMD_REF;
            S_ACT:             c = CMD_ACT;
            S_ACCESS:          c = isWrite ? CMD_WR : CMD_RD;
            default:           c = CMD_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/qram_gap_timer.sv
// Loadable down-counter used for every timing gap; done_o is high while the
// count sits at zero.
module qram_gap_timer
    import qram_ddr_pkg::*;
#(
    parameter logic [TIMER_W-1:0] RESET_VAL = '0
) (
    input  logic               Clock_i,
    input  logic               Reset_i,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] loadVal_i,
    output logic               done_o
);

    logic [TIMER_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = loadVal_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge Clock_i) begin
        if (Reset_i) begin
            count_q <= RESET_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/qram_cmd_sequencer.sv
// Closed-page command sequencer in front of the QRAM SDRAM core: power-up
// init, ACT/RD/WR/PRE per request, periodic refresh and read-data return.
module qram_cmd_sequencer
    import qram_ddr_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int T_INIT = 16,
    parameter int T_RCD  = 2,
    parameter int T_RP   = 2,
    parameter int T_RFC  = 4,
    parameter int T_WR   = 2,
    parameter int CL     = 2,
    parameter int T_REFI = 64
) (
    input  logic              Clock_i,
    input  logic              Reset_i,
    input  logic              ReqValid_i,
    output logic              ReqReady_o,
    input  logic              ReqWrite_i,
    input  logic [ADDR_W-1:0] ReqAddr_i,
    input  logic [DATA_W-1:0] ReqWData_i,
    output logic              RspValid_o,
    output logic [DATA_W-1:0] RspRData_o,
    output logic [2:0]        CmdCode_o,
    output logic [ADDR_W-1:0] CmdAddr_o,
    output logic [DATA_W-1:0] WrData_o,
    input  logic [DATA_W-1:0] QramRData_i,
    output logic              InitDone_o
);

    localparam int REF_W = $clog2(T_REFI + 1);
    localparam logic [REF_W-1:0] REF_DUE = REF_W'(T_REFI);

    state_e              state_q, state_d;
    logic                tLoad;
    logic [TIMER_W-1:0]  tVal;
    logic                tDone;
    logic                accept;
    logic                refreshPending;

    logic                reqWrite_q, reqWrite_d;
    logic [ADDR_W-1:0]   reqAddr_q, reqAddr_d;
    logic [DATA_W-1:0]   reqWData_q, reqWData_d;
    logic [REF_W-1:0]    refCnt_q, refCnt_d;

    cmd_e                cmd_q, cmd_d;
    logic [ADDR_W-1:0]   cmdAddr_q, cmdAddr_d;
    logic [DATA_W-1:0]   wrData_q, wrData_d;
    logic                rspValid_q, rspValid_d;
    logic [DATA_W-1:0]   rspRData_q, rspRData_d;
    logic                initDone_q, initDone_d;

    qram_gap_timer #(
        .RESET_VAL (gapLoad(T_INIT))
    ) uTimer (
        .Clock_i   (Clock_i),
        .Reset_i   (Reset_i),
        .load_i    (tLoad),
        .loadVal_i (tVal),
        .done_o    (tDone)
    );

    assign refreshPending = (refCnt_q == REF_DUE);
    assign ReqReady_o     = (state_q == S_IDLE) && !refreshPending;
    assign accept         = ReqValid_i && ReqReady_o;

    // Sequencing only; every gap is measured by the shared timer, which is
    // loaded by the single-cycle command state preceding each wait state.
    always_comb begin
        state_d = state_q;
        tLoad   = 1'b0;
        tVal    = '0;
        case (state_q)
            S_INIT_WAIT: if (tDone) state_d = S_INIT_PRE;
            S_INIT_PRE: begin
                tLoad   = 1'b1;
                tVal    = gapLoad(T_RP - 1);
                state_d = (T_RP > 1) ? S_INIT_RP : S_INIT_REF;
            end
            S_INIT_RP:   if (tDone) state_d = S_INIT_REF;
            S_INIT_REF: begin
                tLoad   = 1'b1;
                tVal    = gapLoad(T_RFC - 1);
                state_d = (T_RFC > 1) ? S_INIT_RFC : S_IDLE;
            end
            S_INIT_RFC:  if (tDone) state_d = S_IDLE;
            S_IDLE: begin
                if (refreshPending) begin
                    state_d = S_REF;
                end else if (accept) begin
                    state_d = S_ACT;
                end
            end
            S_ACT: begin
                tLoad   = 1'b1;
                tVal    = gapLoad(T_RCD - 1);
                state_d = (T_RCD > 1) ? S_TRCD : S_ACCESS;
            end
            S_TRCD:      if (tDone) state_d = S_ACCESS;
            S_ACCESS: begin
                tLoad = 1'b1;
                if (reqWrite_q) begin
                    tVal    = gapLoad(T_WR - 1);
                    state_d = (T_WR > 1) ? S_TDATA : S_PRE;
                end else begin
                    tVal    = gapLoad(CL);
                    state_d = S_TDATA;
                end
            end
            S_TDATA:     if (tDone) state_d = S_PRE;
            S_PRE: begin
                tLoad   = 1'b1;
                tVal    = gapLoad(T_RP - 1);
                state_d = (T_RP > 1) ? S_TRP : S_IDLE;
            end
            S_TRP:       if (tDone) state_d = S_IDLE;
            S_REF: begin
                tLoad   = 1'b1;
                tVal    = gapLoad(T_RFC - 1);
                state_d = (T_RFC > 1) ? S_TRFC : S_IDLE;
            end
            S_TRFC:      if (tDone) state_d = S_IDLE;
            default:     state_d = S_INIT_WAIT;
        endcase
    end

    // Outputs are registered from the next state so the command appears in
    // the same cycle the FSM occupies the corresponding state.
    always_comb begin
        reqWrite_d = accept ? ReqWrite_i : reqWrite_q;
        reqAddr_d  = accept ? ReqAddr_i  : reqAddr_q;
        reqWData_d = accept ? ReqWData_i : reqWData_q;

        cmd_d      = stateCmd(state_d, reqWrite_d);
        cmdAddr_d  = (state_d == S_ACT || state_d == S_ACCESS) ? reqAddr_d : '0;
        wrData_d   = (state_d == S_ACCESS && reqWrite_d) ? reqWData_d : '0;

        rspValid_d = (state_q == S_TDATA) && tDone && !reqWrite_q;
        rspRData_d = rspValid_d ? QramRData_i : rspRData_q;
        initDone_d = initDone_q || (state_d == S_IDLE);

        refCnt_d   = refCnt_q;
        if (state_d == S_REF) begin
            refCnt_d = '0;
        end else if (initDone_q && !refreshPending) begin
            refCnt_d = refCnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clock_i) begin
        if (Reset_i) begin
            state_q    <= S_INIT_WAIT;
            reqWrite_q <= 1'b0;
            reqAddr_q  <= '0;
            reqWData_q <= '0;
            refCnt_q   <= '0;
            cmd_q      <= CMD_NOP;
            cmdAddr_q  <= '0;
            wrData_q   <= '0;
            rspValid_q <= 1'b0;
            rspRData_q <= '0;
            initDone_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            reqWrite_q <= reqWrite_d;
            reqAddr_q  <= reqAddr_d;
            reqWData_q <= reqWData_d;
            refCnt_q   <= refCnt_d;
            cmd_q      <= cmd_d;
            cmdAddr_q  <= cmdAddr_d;
            wrData_q   <= wrData_d;
            rspValid_q <= rspValid_d;
            rspRData_q <= rspRData_d;
            initDone_q <= initDone_d;
        end
    end

    assign CmdCode_o  = cmd_q;
    assign CmdAddr_o  = cmdAddr_q;
    assign WrData_o   = wrData_q;
    assign RspValid_o = rspValid_q;
    assign RspRData_o = rspRData_q;
    assign InitDone_o = initDone_q;

endmodule

// File: tb/tb_qram_cmd_sequencer.sv
// Randomized bench for qram_cmd_sequencer: a cycle-schedule reference model
// predicts commands and handshakes, and a scoreboard checks read returns.
module tb_qram_cmd_sequencer;

    localparam int T_INIT = 16;
    localparam int T_RCD  = 2;
    localparam int T_RP   = 2;
    localparam int T_RFC  = 4;
    localparam int T_WR   = 2;
    localparam int CL     = 2;
    localparam int T_REFI = 64;
    localparam int INIT_DONE = T_INIT + T_RP + T_RFC;

    localparam int NOP = 0, ACT = 1, RD = 2, WR = 3, PRE = 4, REF = 5;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        ReqValid = 1'b0;
    logic        ReqWrite = 1'b0;
    logic [11:0] ReqAddr = '0;
    logic [7:0]  ReqWData = '0;
    logic [7:0]  QramRData = '0;
    logic        ReqReady, RspValid, InitDone;
    logic [7:0]  RspRData, WrData;
    logic [2:0]  CmdCode;
    logic [11:0] CmdAddr;

    qram_cmd_sequencer dut (
        .Clock_i     (Clock),
        .Reset_i     (Reset),
        .ReqValid_i  (ReqValid),
        .ReqReady_o  (ReqReady),
        .ReqWrite_i  (ReqWrite),
        .ReqAddr_i   (ReqAddr),
        .ReqWData_i  (ReqWData),
        .RspValid_o  (RspValid),
        .RspRData_o  (RspRData),
        .CmdCode_o   (CmdCode),
        .CmdAddr_o   (CmdAddr),
        .WrData_o    (WrData),
        .QramRData_i (QramRData),
        .InitDone_o  (InitDone)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int         due;
        logic [7:0] data;
    } rsp_t;

    int   testsRun = 0;
    int   testsFailed = 0;
    int   cyc = 0;
    int   idleFrom, refBase;
    bit   started = 0;
    logic expReady, expInit;
    int   expCmd[int];
    int   expAddr[int];
    int   expWData[int];
    rsp_t rspQ[$];
    logic [7:0] qdata[0:8191];

    logic        pendV = 1'b0;
    logic        pendW = 1'b0;
    logic [11:0] pendA = '0;
    logic [7:0]  pendD = '0;

    task automatic check(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
        end
    endtask

    // Model restarts from the rules: init commands at fixed offsets and an
    // empty schedule; cycle 0 is the first cycle with Reset low.
    task automatic resetModel();
        expCmd.delete();
        expAddr.delete();
        expWData.delete();
        rspQ.delete();
        idleFrom = INIT_DONE;
        refBase  = INIT_DONE;
        expCmd[T_INIT] = PRE;
        expCmd[T_INIT + T_RP] = REF;
        for (int i = 0; i < 8192; i++) qdata[i] = 8'($urandom_range(0, 255));
        cyc = 0;
    endtask

    task automatic modelCycle(input logic v, input logic w, input logic [11:0] a,
                              input logic [7:0] d, input logic r, output logic accepted);
        bit idle;
        int cnt, acc, pre;
        idle = (cyc >= idleFrom);
        cnt = cyc - refBase;
        if (cnt > T_REFI) cnt = T_REFI;
        expInit  = (cyc >= INIT_DONE);
        expReady = idle && (cnt < T_REFI);
        accepted = 1'b0;
        if (!r && idle) begin
            if (cnt >= T_REFI) begin
                expCmd[cyc + 1] = REF;
                refBase  = cyc + 1;
                idleFrom = cyc + 1 + T_RFC;
            end else if (v) begin
                accepted = 1'b1;
                acc = cyc + T_RCD + 1;
                expCmd[cyc + 1]  = ACT;
                expAddr[cyc + 1] = a;
                expCmd[acc]      = w ? WR : RD;
                expAddr[acc]     = a;
                expWData[acc]    = d;
                if (w) begin
                    pre = acc + T_WR;
                end else begin
                    pre = acc + CL + 1;
                    rspQ.push_back('{due: pre, data: qdata[acc + CL]});
                end
                expCmd[pre] = PRE;
                idleFrom = pre + T_RP;
            end
        end
    endtask

    task automatic checkOutput();
        int ec, ea;
        ec = expCmd.exists(cyc) ? expCmd[cyc] : NOP;
        ea = (ec == ACT || ec == RD || ec == WR) ? expAddr[cyc] : 0;
        check("CmdCode", int'(CmdCode), ec);
        check("CmdAddr", int'(CmdAddr), ea);
        if (ec == WR) check("WrData", int'(WrData), expWData[cyc]);
        check("ReqReady", int'(ReqReady), int'(expReady));
        check("InitDone", int'(InitDone), int'(expInit));
        if (cyc == 0) check("RspRDataReset", int'(RspRData), 0);
    endtask

    task automatic applyStimulus(input logic v, input logic w, input logic [11:0] a,
                                 input logic [7:0] d, input logic r, output logic accepted);
        ReqValid  = v;
        ReqWrite  = w;
        ReqAddr   = a;
        ReqWData  = d;
        QramRData = qdata[cyc];
        Reset     = r;
        modelCycle(v, w, a, d, r, accepted);
        @(negedge Clock);
        checkOutput();
        @(posedge Clock);
        #1;
        if (r) begin
            Reset = 1'b0;
            resetModel();
        end else begin
            cyc++;
        end
    endtask

    task automatic runPhase(input int cycles, input int rate, input bit resetAfterRd);
        bit   didReset;
        logic r, acc;
        didReset = 0;
        for (int i = 0; i < cycles; i++) begin
            r = 1'b0;
            if (!pendV && $urandom_range(0, 99) < rate) begin
                pendV = 1'b1;
                pendW = 1'($urandom_range(0, 1));
                pendA = 12'($urandom_range(0, 4095));
                pendD = 8'($urandom_range(0, 255));
            end
            if (resetAfterRd && !didReset && cyc > 0 && expCmd.exists(cyc - 1) && expCmd[cyc - 1] == RD) begin
                r = 1'b1;
                didReset = 1;
            end
            applyStimulus(pendV, pendW, pendA, pendD, r, acc);
            if (acc) pendV = 1'b0;
            if (resetAfterRd && didReset && cyc > INIT_DONE) break;
        end
        if (resetAfterRd && !didReset) check("ResetAfterRdReached", 0, 1);
    endtask

    // Scoreboard: every read response must arrive exactly when scheduled.
    initial begin
        rsp_t e;
        forever begin
            @(negedge Clock);
            if (started) begin
                if (RspValid) begin
                    if (rspQ.size() == 0) begin
                        check("RspValidUnexpected", 1, 0);
                    end else begin
                        e = rspQ.pop_front();
                        check("RspCycle", cyc, e.due);
                        check("RspRData", int'(RspRData), int'(e.data));
                    end
                end else if (rspQ.size() > 0 && rspQ[0].due <= cyc) begin
                    e = rspQ.pop_front();
                    check("RspValidMissing", 0, 1);
                end
            end
        end
    end

    initial begin
        Reset = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        resetModel();
        Reset = 1'b0;
        started = 1;
        runPhase(40, 0, 0);
        runPhase(1500, 35, 0);
        runPhase(90, 0, 0);
        runPhase(300, 100, 0);
        runPhase(400, 50, 1);
        runPhase(800, 60, 0);
        pendV = 1'b0;
        runPhase(20, 0, 0);
        check("RspQueueDrained", rspQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
